// File: rtl/tap_mac_pkg.sv
// Shared types and sizing helpers for the tap_mac weighted-sum engine.
package tap_mac_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Full-precision width: one product plus enough headroom for NUM+1 of them.
  function automatic int acc_w(input int num, input int width, input int cw);
    return width + cw + $clog2(num + 1);
  endfunction

  function automatic int idx_w(input int num);
    return (num > 0) ? $clog2(num + 1) : 1;
  endfunction

endpackage

// File: rtl/tap_mac_if.sv
// Request/result bundle between a tap_mac and its upstream/downstream logic.
interface tap_mac_if #(
  parameter int NUM   = 0,
  parameter int WIDTH = 8,
  parameter int CW    = 8,
  parameter int ACC_W = tap_mac_pkg::acc_w(NUM, WIDTH, CW)
);
  logic                          start;
  logic [(NUM+1)*WIDTH-1:0]      taps;
  logic [(NUM+1)*CW-1:0]         coefs;
  logic                          busy;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACC_W-1:0]       out_data;

  modport master (output start, taps, coefs, out_ready,
                  input  busy, out_valid, out_data);
  modport slave  (input  start, taps, coefs, out_ready,
                  output busy, out_valid, out_data);
endinterface

// File: rtl/tap_mac_dp.sv
// Datapath: snapshot registers, tap/coef select, one signed MAC per cycle,
// and the result register.
module tap_mac_dp
  import tap_mac_pkg::*;
#(
  parameter int NUM   = 0,
  parameter int WIDTH = 8,
  parameter int CW    = 8,
  parameter int ACC_W = acc_w(NUM, WIDTH, CW),
  parameter int IDX_W = idx_w(NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      acc_en,
  input  logic                      fin,
  input  logic [IDX_W-1:0]          idx,
  input  logic [(NUM+1)*WIDTH-1:0]  taps,
  input  logic [(NUM+1)*CW-1:0]     coefs,
  output logic signed [ACC_W-1:0]   out_data
);
  localparam int PW = WIDTH + CW;

  logic [(NUM+1)*WIDTH-1:0] taps_q, taps_d;
  logic [(NUM+1)*CW-1:0]    coefs_q, coefs_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, out_q, out_d, acc_sum;
  logic [WIDTH-1:0]         tap_sel;
  logic [CW-1:0]            coef_sel;
  logic signed [PW-1:0]     tap_ext, coef_ext, prod;

  always_comb begin
    tap_sel  = taps_q[int'(idx)*WIDTH +: WIDTH];
    coef_sel = coefs_q[int'(idx)*CW +: CW];
    tap_ext  = PW'($signed(tap_sel));
    coef_ext = PW'($signed(coef_sel));
    prod     = tap_ext * coef_ext;
    acc_sum  = acc_q + ACC_W'(prod);

    taps_d  = taps_q;
    coefs_d = coefs_q;
    acc_d   = acc_q;
    out_d   = out_q;
    if (load) begin
      taps_d  = taps;
      coefs_d = coefs;
      acc_d   = '0;
    end else if (acc_en) begin
      acc_d = acc_sum;
    end
    if (fin) out_d = acc_sum;
  end

  // NOTE: snapshot registers are ordinary flops, so they are reset like all other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q  <= '0;
      coefs_q <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      taps_q  <= taps_d;
      coefs_q <= coefs_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign out_data = out_q;

endmodule

// File: rtl/tap_mac.sv
// Sequential weighted-sum engine: IDLE/RUN/DONE control and tap index,
// one product per cycle through tap_mac_dp, valid/ready result hand-off.
module tap_mac
  import tap_mac_pkg::*;
#(
  parameter int NUM   = 0,
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic      clk,
  input  logic      rst,
  tap_mac_if.slave  bus
);
  localparam int ACC_W = acc_w(NUM, WIDTH, CW);
  localparam int IDX_W = idx_w(NUM);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             dp_load, dp_acc, dp_fin;

  // NOTE: every signal gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    dp_load = 1'b0;
    dp_acc  = 1'b0;
    dp_fin  = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.start) begin
        dp_load = 1'b1;
        idx_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        dp_acc = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM)) begin
          dp_fin  = 1'b1;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: if (bus.out_ready) begin
        valid_d = 1'b0;
        state_d = S_IDLE;
        // Consume and accept a new request on the same edge.
        if (bus.start) begin
          dp_load = 1'b1;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  tap_mac_dp #(
    .NUM(NUM), .WIDTH(WIDTH), .CW(CW), .ACC_W(ACC_W), .IDX_W(IDX_W)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (dp_load),
    .acc_en   (dp_acc),
    .fin      (dp_fin),
    .idx      (idx_q),
    .taps     (bus.taps),
    .coefs    (bus.coefs),
    .out_data (bus.out_data)
  );

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_tap_mac.sv
// Scoreboard bench for tap_mac: a NUM=3 instance for the main scenarios and
// a NUM=0 instance for the single-tap build.
module tb_tap_mac;
  localparam int NUM_A = 3;
  localparam int NUM_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    longint data;
    int     due;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  bit   pv_a = 1'b0;
  bit   pv_b = 1'b0;

  tap_mac_if #(.NUM(NUM_A), .WIDTH(8), .CW(8)) bus_a ();
  tap_mac_if #(.NUM(NUM_B), .WIDTH(8), .CW(8)) bus_b ();

  tap_mac #(.NUM(NUM_A), .WIDTH(8), .CW(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  tap_mac #(.NUM(NUM_B), .WIDTH(8), .CW(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  // One sample of a result port: latency on the rising edge of out_valid,
  // data every cycle it is held, pop when the consume edge is coming.
  task automatic observe(input bit unit_b, input logic v, input logic r,
                         input logic signed [63:0] d, input bit pv);
    exp_t e;
    if (v !== 1'b1) return;
    if ((unit_b ? q_b.size() : q_a.size()) == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_result unit=%0d at cycle %0d: got %0d, required none",
               unit_b, cyc, d);
      return;
    end
    e = unit_b ? q_b[0] : q_a[0];
    if (!pv) check(unit_b ? "latency_b" : "latency_a", cyc, e.due);
    check(unit_b ? "out_data_b" : "out_data_a", d, e.data);
    if (r === 1'b1) begin
      if (unit_b) void'(q_b.pop_front());
      else        void'(q_a.pop_front());
    end
  endtask

  always @(negedge clk) begin
    #1;
    observe(1'b0, bus_a.out_valid, bus_a.out_ready, $signed(bus_a.out_data), pv_a);
    observe(1'b1, bus_b.out_valid, bus_b.out_ready, $signed(bus_b.out_data), pv_b);
    pv_a = bus_a.out_valid;
    pv_b = bus_b.out_valid;
  end

  // Called on a falling edge; the request is accepted on the next rising edge.
  task automatic issue_a(input logic [31:0] t, input logic [31:0] c, input longint e);
    bus_a.taps  = t;
    bus_a.coefs = c;
    bus_a.start = 1'b1;
    q_a.push_back('{data: e, due: cyc + NUM_A + 2});
    @(negedge clk);
    bus_a.start = 1'b0;
  endtask

  task automatic issue_b(input logic [7:0] t, input logic [7:0] c, input longint e);
    bus_b.taps  = t;
    bus_b.coefs = c;
    bus_b.start = 1'b1;
    q_b.push_back('{data: e, due: cyc + NUM_B + 2});
    @(negedge clk);
    bus_b.start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout at cycle %0d: got %0d pending, required 0",
               cyc, q_a.size() + q_b.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.start = 1'b0; bus_a.taps = '0; bus_a.coefs = '0; bus_a.out_ready = 1'b1;
    bus_b.start = 1'b0; bus_b.taps = '0; bus_b.coefs = '0; bus_b.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy_a",  bus_a.busy, 0);
    check("rst_valid_a", bus_a.out_valid, 0);
    check("rst_data_a",  $signed(bus_a.out_data), 0);
    check("rst_busy_b",  bus_b.busy, 0);
    check("rst_valid_b", bus_b.out_valid, 0);
    check("rst_data_b",  $signed(bus_b.out_data), 0);

    // Basic sum, started on the first edge after reset release.
    rst = 1'b0;
    issue_a(32'h04030201, 32'h01010101, 10);
    wait_drain(30);
    check("busy_after_basic", bus_a.busy, 0);

    // Signed extremes.
    issue_a(32'h80808080, 32'h80808080, 65536);
    wait_drain(30);
    issue_a(32'h7F7F7F7F, 32'h80808080, -65024);
    wait_drain(30);

    // Single-tap build.
    issue_b(8'hFB, 8'h03, -15);
    wait_drain(30);

    // Backpressure, mid-run tap change, ignored start in DONE.
    bus_a.out_ready = 1'b0;
    issue_a(32'h04030201, 32'h01010101, 10);
    bus_a.taps = 32'h09090909;
    repeat (4) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (4) @(negedge clk);
    bus_a.out_ready = 1'b1;
    wait_drain(30);
    check("busy_after_backpressure", bus_a.busy, 0);

    // Back-to-back with start held high: results every 5 cycles.
    bus_a.taps  = 32'h04030201;
    bus_a.coefs = 32'h01010101;
    bus_a.start = 1'b1;
    q_a.push_back('{data: 10,    due: cyc + 5});
    q_a.push_back('{data: -18,   due: cyc + 10});
    q_a.push_back('{data: 64516, due: cyc + 15});
    @(negedge clk);
    bus_a.taps  = 32'hFC03FE01;
    bus_a.coefs = 32'h08070605;
    repeat (5) @(negedge clk);
    bus_a.taps  = 32'h7F7F7F7F;
    bus_a.coefs = 32'h7F7F7F7F;
    repeat (5) @(negedge clk);
    bus_a.start = 1'b0;
    wait_drain(40);
    check("busy_after_b2b", bus_a.busy, 0);

    // Reset two cycles into a run: aborted result is never presented.
    bus_a.taps  = 32'h05050505;
    bus_a.coefs = 32'h05050505;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy",  bus_a.busy, 0);
    check("midrun_rst_valid", bus_a.out_valid, 0);
    check("midrun_rst_data",  $signed(bus_a.out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    issue_a(32'h281E140A, 32'h01010101, 100);
    wait_drain(30);

    check("scoreboard_empty", q_a.size() + q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
